hazard_control_unit: RTL and testbench

Pipeline hazard and stall controller for the 16-bit five-stage datapath, located in the ID stage next to the forwarding logic. It detects the hazards that forwarding cannot cover: load-use, branch-operand-not-ready and multi-cycle multiply/divide occupancy. It drives the PC, IF/ID, ID/EX and EX/MEM write, bubble and flush controls, and keeps a saturating stall-cycle counter for performance checks.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/sat_counter16.sv | 27 ++
 rtl/hazard_control_unit.sv | 124 ++++++++++++
 tb/tb_hazard_control_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared definitions for the 16-bit five-stage pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int REG_W = 4;

    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] MD_STALL = 1'b1;

    // All-zero word decodes as a no-op in the stage registers.
    localparam logic [15:0] NOP_INSN = 16'h0000;

    function automatic logic reg_match(input logic [REG_W-1:0] a,
                                       input logic [REG_W-1:0] b);
        return a == b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter16.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter16
// Description : 16-bit up-counter that sticks at all-ones, async clear.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [15:0] count
);

    logic [15:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 16'h0000;
        end else if (inc && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'h0001;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_control_unit
// Description : ID-stage stall/bubble/flush control for load-use, branch
//               operand and multi-cycle mul/div hazards.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_control_unit
    import cpu_pkg::*;
#(
    parameter int unsigned MD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_op1,
    input  logic [REG_W-1:0] id_op2,
    input  logic             id_uses_op2,
    input  logic             id_is_branch,
    input  logic             id_branch_taken,
    input  logic [REG_W-1:0] ex_op1,
    input  logic [1:0]       ex_regwrite,
    input  logic             ex_memread,
    input  logic             ex_muldiv,
    input  logic [REG_W-1:0] mem_op1,
    input  logic             mem_memread,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             exmem_bubble,
    output logic             ifid_flush,
    output logic             md_busy,
    output logic [15:0]      stall_cycles
);

    localparam logic [3:0] MD_LOAD = 4'(MD_CYCLES - 2);

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;

    logic w_lu;
    logic w_br;
    logic w_md;
    logic w_occupied;
    logic w_pc_write;

    assign w_lu = ex_memread &&
                  (reg_match(ex_op1, id_op1) || (id_uses_op2 && reg_match(ex_op1, id_op2)));
    assign w_br = id_is_branch &&
                  (((ex_regwrite != 2'b00) && reg_match(ex_op1, id_op1)) ||
                   (mem_memread && reg_match(mem_op1, id_op1)));
    assign w_md = (r_state == RUN) && ex_muldiv;

    // Cycles in which the mul/div owns EX; hazard terms are ignored here.
    assign w_occupied = w_md || ((r_state == MD_STALL) && (r_cnt != 4'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            RUN: begin
                if (ex_muldiv) begin
                    w_state_nxt = MD_STALL;
                    w_cnt_nxt   = MD_LOAD;
                end
            end
            MD_STALL: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_comb begin
        w_pc_write   = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        if (w_occupied) begin
            w_pc_write   = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
        end else if (w_lu || w_br) begin
            w_pc_write  = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // Busy flags the held-occupancy cycles after issue, not the issue cycle itself.
    assign md_busy    = (r_state == MD_STALL) && (r_cnt != 4'd0);
    assign pc_write   = w_pc_write;
    assign ifid_flush = id_branch_taken && w_pc_write;

    sat_counter16 u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!w_pc_write),
        .count (stall_cycles)
    );

endmodule
`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_control_unit
// Description : Directed scoreboard bench for hazard_control_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_control_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  id_op1, id_op2, ex_op1, mem_op1;
    logic        id_uses_op2, id_is_branch, id_branch_taken;
    logic [1:0]  ex_regwrite;
    logic        ex_memread, ex_muldiv, mem_memread;
    logic        pc_write, ifid_write, idex_write, idex_bubble;
    logic        exmem_bubble, ifid_flush, md_busy;
    logic [15:0] stall_cycles;

    // {pc_write, ifid_write, idex_write, idex_bubble, exmem_bubble, ifid_flush, md_busy}
    localparam logic [6:0] C_NORMAL = 7'b111_0_0_0_0;
    localparam logic [6:0] C_FLUSH  = 7'b111_0_0_1_0;
    localparam logic [6:0] C_HZ     = 7'b001_1_0_0_0;
    localparam logic [6:0] C_MD_ISS = 7'b000_0_1_0_0;
    localparam logic [6:0] C_MD_OCC = 7'b000_0_1_0_1;

    typedef struct {
        string       tag;
        logic [6:0]  ctrl;
        logic [15:0] stall;
    } sb_t;

    sb_t         sb[$];
    int          passes = 0;
    int          total  = 0;
    logic [15:0] exp_stall = 16'h0000;

    always #5 clk = ~clk;

    hazard_control_unit #(.MD_CYCLES(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_op1          (id_op1),
        .id_op2          (id_op2),
        .id_uses_op2     (id_uses_op2),
        .id_is_branch    (id_is_branch),
        .id_branch_taken (id_branch_taken),
        .ex_op1          (ex_op1),
        .ex_regwrite     (ex_regwrite),
        .ex_memread      (ex_memread),
        .ex_muldiv       (ex_muldiv),
        .mem_op1         (mem_op1),
        .mem_memread     (mem_memread),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .idex_write      (idex_write),
        .idex_bubble     (idex_bubble),
        .exmem_bubble    (exmem_bubble),
        .ifid_flush      (ifid_flush),
        .md_busy         (md_busy),
        .stall_cycles    (stall_cycles)
    );

    task automatic clear_inputs();
        id_op1 = 4'h0; id_op2 = 4'h0; ex_op1 = 4'h0; mem_op1 = 4'h0;
        id_uses_op2 = 1'b0; id_is_branch = 1'b0; id_branch_taken = 1'b0;
        ex_regwrite = 2'b00; ex_memread = 1'b0; ex_muldiv = 1'b0;
        mem_memread = 1'b0;
    endtask

    task automatic check_front();
        sb_t        e;
        logic [6:0] obs;
        if (sb.size() == 0) begin
            total++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e   = sb.pop_front();
        obs = {pc_write, ifid_write, idex_write, idex_bubble,
               exmem_bubble, ifid_flush, md_busy};
        total++;
        assert (obs === e.ctrl) passes++;
        else $error("FAIL %s ctrl observed=%b expected=%b", e.tag, obs, e.ctrl);
        total++;
        assert (stall_cycles === e.stall) passes++;
        else $error("FAIL %s stall_cycles observed=%0d expected=%0d",
                    e.tag, stall_cycles, e.stall);
    endtask

    // Called 1 time unit after a rising edge with inputs already driven.
    task automatic step(input string tag, input logic [6:0] ctrl);
        sb.push_back('{tag, ctrl, exp_stall});
        #3;
        check_front();
        if (!ctrl[6] && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'h1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        #2;
        sb.push_back('{"reset", C_NORMAL, 16'h0000});
        check_front();
        @(posedge clk); #1;
        rst_n = 1'b1;

        step("idle", C_NORMAL);

        // Load-use on op2, then no hazard
        ex_memread = 1'b1; ex_op1 = 4'h3; id_op2 = 4'h3; id_uses_op2 = 1'b1; id_op1 = 4'h1;
        step("lu_op2", C_HZ);
        clear_inputs();
        step("lu_after", C_NORMAL);
        ex_memread = 1'b1; ex_op1 = 4'h3; id_op2 = 4'h3; id_uses_op2 = 1'b0; id_op1 = 4'h1;
        step("lu_op2_unused", C_NORMAL);
        ex_memread = 1'b1; ex_op1 = 4'h7; id_op1 = 4'h7;
        step("lu_op1", C_HZ);
        clear_inputs();

        // Branch after ALU op then after MEM load: two one-cycle stalls
        id_is_branch = 1'b1; id_op1 = 4'h5; ex_regwrite = 2'b01; ex_op1 = 4'h5;
        step("br_ex", C_HZ);
        ex_regwrite = 2'b00; mem_memread = 1'b1; mem_op1 = 4'h5;
        step("br_mem", C_HZ);
        mem_memread = 1'b0;
        step("br_clear", C_NORMAL);
        ex_regwrite = 2'b10;
        step("br_ex_rw2", C_HZ);
        ex_regwrite = 2'b00; mem_memread = 1'b0; mem_op1 = 4'h5;
        step("br_mem_noload", C_NORMAL);
        clear_inputs();

        // Taken branch stalled by load-use is not flushed; flushed once it proceeds
        id_is_branch = 1'b1; id_branch_taken = 1'b1; id_op1 = 4'h2;
        ex_memread = 1'b1; ex_op1 = 4'h2;
        step("taken_stalled", C_HZ);
        ex_memread = 1'b0; ex_op1 = 4'h0;
        step("taken_flush", C_FLUSH);
        clear_inputs();

        // Mul/div: 3 stall cycles, release on the 4th; hazards ignored while occupied
        ex_muldiv = 1'b1;
        step("md_issue", C_MD_ISS);
        ex_memread = 1'b1; ex_op1 = 4'h4; id_op1 = 4'h4;
        step("md_occ1", C_MD_OCC);
        ex_memread = 1'b0;
        step("md_occ2", C_MD_OCC);
        step("md_release", C_NORMAL);
        clear_inputs();
        step("md_done", C_NORMAL);

        // md wins over lu in RUN; lu re-evaluated in the release cycle
        ex_muldiv = 1'b1; ex_memread = 1'b1; ex_op1 = 4'h9; id_op1 = 4'h9;
        step("md_lu_issue", C_MD_ISS);
        step("md_lu_occ1", C_MD_OCC);
        step("md_lu_occ2", C_MD_OCC);
        step("md_lu_release", C_HZ);
        clear_inputs();
        step("md_lu_done", C_NORMAL);

        // Async reset while MD_STALL with cnt==1
        ex_muldiv = 1'b1;
        step("rst_md_issue", C_MD_ISS);
        step("rst_md_occ1", C_MD_OCC);
        #2;
        rst_n = 1'b0;
        ex_muldiv = 1'b0;
        #1;
        exp_stall = 16'h0000;
        sb.push_back('{"rst_async", C_NORMAL, 16'h0000});
        check_front();
        @(posedge clk); #1;
        rst_n = 1'b1;
        step("rst_after", C_NORMAL);

        // Saturation: hold a load-use stall across the counter wrap point
        rst_n = 1'b0; #1; rst_n = 1'b1;
        exp_stall = 16'h0000;
        ex_memread = 1'b1; ex_op1 = 4'h6; id_op1 = 4'h6;
        repeat (65534) @(posedge clk);
        #1;
        sb.push_back('{"sat_fffe", C_HZ, 16'hFFFE});
        check_front();
        repeat (6) @(posedge clk);
        #1;
        sb.push_back('{"sat_hold", C_HZ, 16'hFFFF});
        check_front();
        clear_inputs();
        @(posedge clk); #1;
        sb.push_back('{"sat_idle", C_NORMAL, 16'hFFFF});
        check_front();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
`default_nettype wire
